// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile : architectural general-purpose register file, 32 x 32-bit.
//
// One write port fed by the write-back stage.
// Two independent combinational read ports consumed by decode.
// Register 0 is hardwired to zero.
//
// Optional feature, controlled by the macro REGFILE_BYPASS_EN:
//   - Defined: a read of the address being written in the same cycle
//     returns wdata before the edge (WB->ID bypass).
//   - Undefined: such a read returns the old array value.
//
// Ports:
//   clk     in   1   sole clock; writes commit on the rising edge
//   rst     in   1   asynchronous, active-high; clears the array and
//                    forces both read ports to zero
//   we      in   1   write enable (wb_wreg)
//   waddr   in   5   write destination (wb_wd)
//   wdata   in  32   write data (wb_wdata)
//   re1     in   1   read-port-1 enable
//   raddr1  in   5   read-port-1 address
//   rdata1  out 32   read-port-1 data, combinational
//   re2     in   1   read-port-2 enable
//   raddr2  in   5   read-port-2 address
//   rdata2  out 32   read-port-2 data, combinational
//
// There is no handshake: writes are accepted unconditionally whenever
// we is high on a rising edge, and reads never stall.
// ---------------------------------------------------------------------------
module regfile #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int DW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              re1,
    input  logic [REG_AW-1:0] raddr1,
    output logic [DW-1:0]     rdata1,
    input  logic              re2,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DW-1:0]     rdata2
);

    logic [DW-1:0] r_regs [REG_NUM];

    // A write to r0 is discarded here. Because of that, r_regs[0] holds
    // zero from reset onward. The read paths also decode address 0
    // explicitly, so r0 reads as zero even with the bypass active.
    logic w_wr_en;
    assign w_wr_en = we && (waddr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    logic w_hit1;
    logic w_hit2;

`ifdef REGFILE_BYPASS_EN
    // The address-0 case is already excluded by w_wr_en.
    assign w_hit1 = w_wr_en && re1 && (waddr == raddr1);
    assign w_hit2 = w_wr_en && re2 && (waddr == raddr2);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    // Read-port priority: reset, then enable, then r0, then bypass,
    // then the array.
    always_comb begin
        rdata1 = '0;
        if (rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (w_hit1) begin
            rdata1 = wdata;
        end else begin
            rdata1 = r_regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (w_hit2) begin
            rdata2 = wdata;
        end else begin
            rdata2 = r_regs[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int n_cmp;
    int n_fail;

    regfile dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge.
    // Inputs change and are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    logic [31:0] exp_v;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        we     = 1'b0;
        waddr  = '0;
        wdata  = '0;
        re1    = 1'b1;
        raddr1 = 5'd5;
        re2    = 1'b1;
        raddr2 = 5'd31;
        #2;
        check("reset_rd1", rdata1, 32'h0);
        check("reset_rd2", rdata2, 32'h0);
        tick();
        rst = 1'b0;
        #1;

        // Reset between edges clears r5 immediately.
        write_reg(5'd5, 32'h12345678);
        #1;
        check("r5_written", rdata1, 32'h12345678);
        #1 rst = 1'b1;
        #1;
        check("rst_async_rd1", rdata1, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_release_rd1", rdata1, 32'h0);

        // Basic write and read on both ports.
        tick();
        write_reg(5'd3, 32'hDEADBEEF);
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        #1;
        check("basic_rd1", rdata1, 32'hDEADBEEF);
        check("basic_rd2", rdata2, 32'hDEADBEEF);
        re1 = 1'b0;
        #1;
        check("re1_low", rdata1, 32'h0);
        check("re2_still", rdata2, 32'hDEADBEEF);
        re1 = 1'b1;

        // Register 0 is hardwired to zero, including during the write cycle.
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hFFFFFFFF;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        #1;
        check("r0_during_wr_rd1", rdata1, 32'h0);
        check("r0_during_wr_rd2", rdata2, 32'h0);
        tick();
        we = 1'b0;
        check("r0_after_wr_rd1", rdata1, 32'h0);
        check("r0_after_wr_rd2", rdata2, 32'h0);

        // A write of X data to address 0 has no effect.
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 'x;
        tick();
        we    = 1'b0;
        wdata = '0;
        check("r0_x_write", rdata1, 32'h0);

        // Same-cycle write/read hazard on r7.
        write_reg(5'd7, 32'h00000011);
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'h00000022;
        raddr1 = 5'd7;
        raddr2 = 5'd7;
        re2    = 1'b0;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'h00000022;
`else
        exp_v = 32'h00000011;
`endif
        check("hazard_rd1", rdata1, exp_v);
        check("hazard_rd2_disabled", rdata2, 32'h0);
        tick();
        we  = 1'b0;
        re2 = 1'b1;
        #1;
        check("hazard_after_rd1", rdata1, 32'h00000022);
        check("hazard_after_rd2", rdata2, 32'h00000022);

        // Dual independent ports while writing a third register.
        write_reg(5'd1, 32'h0000000A);
        write_reg(5'd2, 32'h0000000B);
        raddr1 = 5'd1;
        raddr2 = 5'd2;
        we     = 1'b1;
        waddr  = 5'd9;
        wdata  = 32'h0000000C;
        #1;
        check("dual_rd1", rdata1, 32'h0000000A);
        check("dual_rd2", rdata2, 32'h0000000B);
        tick();
        we     = 1'b0;
        raddr1 = 5'd9;
        #1;
        check("dual_r9", rdata1, 32'h0000000C);

        // A write whose edge coincides with reset high is lost.
        rst   = 1'b1;
        we    = 1'b1;
        waddr = 5'd4;
        wdata = 32'hCAFEF00D;
        tick();
        we  = 1'b0;
        rst = 1'b0;
        raddr1 = 5'd4;
        raddr2 = 5'd9;
        #1;
        check("rst_lost_wr_r4", rdata1, 32'h0);
        check("rst_cleared_r9", rdata2, 32'h0);

        // Sweep: write every register, then read all of them back on both ports.
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check($sformatf("sweep_rd1_r%0d", i), rdata1, 32'(i) * 32'h01010101);
            check($sformatf("sweep_rd2_r%0d", 31 - i), rdata2, 32'(31 - i) * 32'h01010101);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Architectural general-purpose register file for the five-stage core: 32 × 32-bit registers, one write port fed by the write-back stage, and two read ports consumed by the decode stage. It is the far end of the MEM/WB → WB path: it receives the write-back destination, write enable and data and commits them to architectural state. An optional same-cycle write-to-read bypass removes the WB→ID structural hazard.

## Interface
- `REG_NUM`, 32: number of registers; fixed architectural value.
- `REG_AW`, 5: register address width; log2(`REG_NUM`).
- `DW`, 32: data width.

- `clk`  input  1  sole clock; all writes on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `we`  input  1  write enable from WB stage (`wb_wreg`).
- `waddr`  input  5  write destination (`wb_wd`).
- `wdata`  input  32  write data (`wb_wdata`).
- `re1`  input  1  read-port-1 enable from decode.
- `raddr1`  input  5  read-port-1 address.
- `rdata1`  output  32  read-port-1 data, combinational.
- `re2`  input  1  read-port-2 enable.
- `raddr2`  input  5  read-port-2 address.
- `rdata2`  output  32  read-port-2 data, combinational.

## Operation
- Storage: array `regs[0..31]`, 32 bits each.
- Reset: `rst` high asynchronously clears every `regs[i]` to 0x00000000; while `rst` is high, `rdata1` = `rdata2` = 0 regardless of other inputs and no write occurs.
- Write: on rising `clk` with `rst` low, `we` high and `waddr` ≠ 0, `regs[waddr]` ← `wdata`. Otherwise array holds.
- Register 0: hardwired zero. Writes to address 0 are discarded; reads of address 0 return 0 even with bypass active.
- Read, per port n (independent, identical rules, priority top-down):
  - `rst` high → 0.
  - `ren` low → 0.
  - `raddrn` = 0 → 0.
  - bypass hit (see Configuration) → `wdata`.
  - else → `regs[raddrn]`.
- Both ports may read the same address simultaneously; both return the same value.
- Write and read of different addresses in the same cycle do not interact.
- No other state; no handshakes; block cannot stall.

## Timing
- Write latency: data visible in array after the rising edge that samples `we`; array-path read of that address returns new value from that edge onward.
- Read latency: zero cycles (combinational from `raddrn`, `ren`, `rst`, and — with bypass — `we`, `waddr`, `wdata`).
- Reset assertion takes effect immediately without a clock edge; deassertion is synchronised externally; first write may occur on the first rising edge with `rst` low.
- Reset mid-operation: a write whose edge coincides with `rst` high is lost; array reads 0 afterwards.
- `we` high with X on `wdata` into address 0: no effect on state.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: a port has a bypass hit when `we` high, `waddr` = `raddrn`, `waddr` ≠ 0 and `ren` high; it then returns `wdata` in the same cycle the write is presented (before the edge). Removes the need for a WB→ID forwarding path elsewhere.
- Not defined: no bypass; a read of the address being written in the same cycle returns the old array value; new value visible only after the edge. Decode must then cover the WB→ID hazard by other means (stall or external forwarding).

## Test plan
- Reset: write 0x12345678 to r5, then pulse `rst` high between edges → `rdata1` (re1=1, raddr1=5) reads 0 immediately and after `rst` release.
- Basic write/read: we=1, waddr=3, wdata=0xDEADBEEF, one edge, we=0 → port 1 and port 2 both at address 3 return 0xDEADBEEF; re1=0 → `rdata1` = 0.
- Register 0: we=1, waddr=0, wdata=0xFFFFFFFF, edge → reads of address 0 on both ports return 0, including during the write cycle.
- Same-cycle hazard: r7 holds 0x00000011; present we=1, waddr=7, wdata=0x00000022 with raddr1=7 before the edge → `rdata1` = 0x00000022 with `REGFILE_BYPASS_EN`, 0x00000011 without; after the edge both builds read 0x00000022.
- Dual independent ports: r1=0xA, r2=0xB; raddr1=1, raddr2=2 while writing r9=0xC → `rdata1`=0xA, `rdata2`=0xB, then r9 reads 0xC.
- Write-all sweep: write i×0x01010101 to r1..r31 on consecutive edges, read all back on both ports → exact values, r0 = 0.
